// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer.
// Holds the FSM state encoding, command opcodes and the default write acknowledge byte.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_ACK  = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        RD_SEND = 3'd5
    } state_e;

    localparam logic [7:0] CMD_WRITE        = 8'h01;
    localparam logic [7:0] CMD_READ         = 8'h02;
    localparam logic [7:0] ACK_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Idle counter for the write payload: counts enabled cycles since the last clear and
// pulses timeout when LIMIT cycles have elapsed. Used only under UART_CMD_TIMEOUT_EN.
module uart_cmd_timeout #(
    parameter int LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic timeout
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The counter restarts from zero whenever it is disabled, cleared or has just fired.
    assign timeout = en && !clr && (count_q == CW'(LIMIT - 1));

    always_comb begin
        count_d = count_q + CW'(1);
        if (!en || clr || timeout) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer between UART RX/TX and the packet buffer: 0x01 writes a DEPTH-byte
// payload, 0x02 reads the buffer back. Defining UART_CMD_TIMEOUT_EN adds a write-payload idle timeout.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int         DEPTH          = 512,
    parameter int         AW             = $clog2(DEPTH),
    parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          tx_valid,
    output logic [7:0]    tx_data,
    input  logic          tx_ready,
    output logic          buf_we,
    output logic [AW-1:0] buf_waddr,
    output logic [7:0]    buf_wdata,
    output logic          buf_re,
    output logic [AW-1:0] buf_raddr,
    input  logic [7:0]    buf_rdata,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam logic [AW:0] CNT_LAST = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

    state_e      state_q, state_d;
    logic [AW:0] cnt_q, cnt_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        buf_re_q, buf_re_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cnt_last;
    logic        timeout;

    assign cnt_last = (cnt_q == CNT_LAST);

`ifdef UART_CMD_TIMEOUT_EN
    uart_cmd_timeout #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q == WR_DATA),
        .clr     (rx_valid),
        .timeout (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        buf_re_d   = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        buf_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WRITE) begin
                        state_d = WR_DATA;
                        cnt_d   = '0;
                    end else if (rx_data == CMD_READ) begin
                        state_d  = RD_REQ;
                        cnt_d    = '0;
                        buf_re_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WR_DATA: begin
                // The write port is a pass-through so the byte lands in the same cycle it arrives.
                if (rx_valid) begin
                    buf_we = 1'b1;
                    cnt_d  = cnt_q + CNT_ONE;
                    if (cnt_last) begin
                        state_d    = WR_ACK;
                        tx_valid_d = 1'b1;
                        tx_data_d  = ACK_BYTE;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            WR_ACK: begin
                if (tx_ready) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                end
            end
            RD_REQ: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                state_d    = RD_SEND;
                tx_valid_d = 1'b1;
                tx_data_d  = buf_rdata;
            end
            RD_SEND: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (cnt_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = RD_REQ;
                        cnt_d    = cnt_q + CNT_ONE;
                        buf_re_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            buf_re_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            buf_re_q   <= buf_re_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign buf_waddr = cnt_q[AW-1:0];
    assign buf_wdata = rx_data;
    assign buf_re    = buf_re_q;
    assign buf_raddr = cnt_q[AW-1:0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: a behavioural buffer, scoreboard queues for buffer
// writes and TX bytes, and one task per scenario. Define UART_CMD_TIMEOUT_EN to cover the timeout.
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;
    localparam int DEPTH      = 512;
    localparam int AW         = 9;
    localparam int TB_TIMEOUT = 1000;
    localparam int RD_CYCLES  = 3 * DEPTH;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready = 1'b0;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [7:0]    buf_wdata;
    logic          buf_re;
    logic [AW-1:0] buf_raddr;
    logic [7:0]    buf_rdata = 8'h00;
    logic          busy;
    logic          done;
    logic          err;

    logic [7:0] mem [DEPTH];
    logic       preload_go = 1'b0;

    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];
    wr_t        wr_e;
    logic [7:0] tx_e;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int we_cnt   = 0;
    int re_cnt   = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    uart_cmd_ctrl #(
        .DEPTH          (DEPTH),
        .AW             (AW),
        .ACK_BYTE       (8'hA5),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .buf_we    (buf_we),
        .buf_waddr (buf_waddr),
        .buf_wdata (buf_wdata),
        .buf_re    (buf_re),
        .buf_raddr (buf_raddr),
        .buf_rdata (buf_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Behavioural buffer: synchronous write, read data one cycle after buf_re.
    always @(posedge clk) begin
        if (preload_go) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (buf_we === 1'b1) begin
            mem[buf_waddr] <= buf_wdata;
        end
        if (buf_re === 1'b1) buf_rdata <= mem[buf_raddr];
    end

    // Monitor on the falling edge: scoreboard pops for writes and TX handshakes, stall stability.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (done === 1'b1) done_cnt++;
            if (err === 1'b1) err_cnt++;
            if (buf_re === 1'b1) re_cnt++;
            if (buf_we === 1'b1) begin
                we_cnt++;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL buf_write: unexpected write addr=%0d data=%02h, none required", buf_waddr, buf_wdata);
                end else begin
                    wr_e = exp_wr.pop_front();
                    if (buf_waddr !== wr_e.addr || buf_wdata !== wr_e.data) begin
                        errors++;
                        $display("FAIL buf_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                                 buf_waddr, buf_wdata, wr_e.addr, wr_e.data);
                    end
                end
            end
            if (stall_prev) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== stall_data) begin
                    errors++;
                    $display("FAIL tx_stall: got valid=%b data=%02h, required valid=1 data=%02h",
                             tx_valid, tx_data, stall_data);
                end
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL tx_byte: unexpected byte %02h, none required", tx_data);
                end else begin
                    tx_e = exp_tx.pop_front();
                    if (tx_data !== tx_e) begin
                        errors++;
                        $display("FAIL tx_byte: got %02h, required %02h", tx_data, tx_e);
                    end
                end
            end
            stall_prev = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
            stall_data = tx_data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic preload();
        preload_go = 1'b1;
        cyc();
        preload_go = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            cyc();
            n++;
        end
    endtask

    function automatic logic [7:0] new_pat(input int a);
        return 8'((a * 3 + 7) & 255);
    endfunction

    task automatic push_read_exp(input int new_upto);
        for (int a = 0; a < DEPTH; a++)
            exp_tx.push_back(a < new_upto ? new_pat(a) : (8'(a) ^ 8'h5A));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        checks++; if (tx_valid !== 1'b0)  begin errors++; $display("FAIL reset_tx_valid: got %b, required 0", tx_valid); end
        checks++; if (tx_data !== 8'h00)  begin errors++; $display("FAIL reset_tx_data: got %02h, required 00", tx_data); end
        checks++; if (buf_we !== 1'b0)    begin errors++; $display("FAIL reset_buf_we: got %b, required 0", buf_we); end
        checks++; if (buf_re !== 1'b0)    begin errors++; $display("FAIL reset_buf_re: got %b, required 0", buf_re); end
        checks++; if (buf_waddr !== '0)   begin errors++; $display("FAIL reset_buf_waddr: got %0d, required 0", buf_waddr); end
        checks++; if (buf_raddr !== '0)   begin errors++; $display("FAIL reset_buf_raddr: got %0d, required 0", buf_raddr); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_write();
        int n;
        int we0;
        we0 = we_cnt;
        for (int i = 0; i < DEPTH; i++) exp_wr.push_back(wr_t'{AW'(i), 8'(i)});
        exp_tx.push_back(8'hA5);
        tx_ready = 1'b1;
        send_byte(8'h01);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b, required 1", busy); end
        for (int i = 0; i < DEPTH; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            cyc();
        end
        rx_valid = 1'b0;
        wait_done(10, n);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL write_done: got %b after %0d cycles, required 1", done, n); end
        checks++; if (we_cnt - we0 != DEPTH) begin errors++; $display("FAIL write_count: got %0d, required %0d", we_cnt - we0, DEPTH); end
        checks++; if (exp_wr.size() != 0 || exp_tx.size() != 0) begin
            errors++; $display("FAIL write_leftover: got %0d writes %0d tx pending, required 0 0", exp_wr.size(), exp_tx.size());
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_idle: busy got %b, required 0", busy); end
        cyc();
    endtask

    task automatic test_read();
        int n;
        int re0;
        preload();
        re0 = re_cnt;
        push_read_exp(0);
        tx_ready = 1'b1;
        send_byte(8'h02);
        checks++; if (busy !== 1'b1 || buf_re !== 1'b1 || buf_raddr !== '0) begin
            errors++; $display("FAIL read_start: got busy=%b re=%b raddr=%0d, required 1 1 0", busy, buf_re, buf_raddr);
        end
        wait_done(RD_CYCLES + 20, n);
        checks++; if (n != RD_CYCLES) begin errors++; $display("FAIL read_cycles: got %0d, required %0d", n, RD_CYCLES); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_idle: busy got %b, required 0", busy); end
        checks++; if (re_cnt - re0 != DEPTH) begin errors++; $display("FAIL read_re_count: got %0d, required %0d", re_cnt - re0, DEPTH); end
        checks++; if (exp_tx.size() != 0) begin errors++; $display("FAIL read_leftover: got %0d pending, required 0", exp_tx.size()); end
        cyc();
    endtask

    task automatic test_read_stall();
        int n;
        int err0;
        err0 = err_cnt;
        push_read_exp(0);
        tx_ready = 1'b0;
        send_byte(8'h02);
        n = 0;
        while (done !== 1'b1 && n < 8 * DEPTH + 100) begin
            tx_ready = 1'($urandom_range(0, 1));
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data  = 8'h01;
            cyc();
            n++;
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b after %0d cycles, required 1", done, n); end
        checks++; if (n < RD_CYCLES) begin errors++; $display("FAIL stall_cycles: got %0d, required at least %0d", n, RD_CYCLES); end
        checks++; if (exp_tx.size() != 0) begin errors++; $display("FAIL stall_leftover: got %0d pending, required 0", exp_tx.size()); end
        checks++; if (err_cnt != err0) begin errors++; $display("FAIL stall_rx_dropped: got %0d err pulses, required 0", err_cnt - err0); end
        cyc();
    endtask

    task automatic test_bad_cmd();
        int we0, re0, err0;
        we0 = we_cnt; re0 = re_cnt; err0 = err_cnt;
        send_byte(8'h7F);
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bad_cmd_err: got err=%b busy=%b, required 1 0", err, busy);
        end
        cyc();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_cmd_pulse: got err=%b, required 0", err); end
        cyc();
        checks++; if (we_cnt != we0 || re_cnt != re0 || err_cnt != err0 + 1) begin
            errors++; $display("FAIL bad_cmd_side: got we=%0d re=%0d err=%0d, required 0 0 1", we_cnt - we0, re_cnt - re0, err_cnt - err0);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        preload();
        for (int i = 0; i < 100; i++) exp_wr.push_back(wr_t'{AW'(i), new_pat(i)});
        tx_ready = 1'b1;
        send_byte(8'h01);
        for (int i = 0; i < 100; i++) begin
            rx_valid = 1'b1;
            rx_data  = new_pat(i);
            cyc();
        end
        rx_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || tx_valid !== 1'b0 || exp_wr.size() != 0) begin
            errors++; $display("FAIL abort_reset: got busy=%b tx_valid=%b pending=%0d, required 0 0 0", busy, tx_valid, exp_wr.size());
        end
        cyc();
        push_read_exp(100);
        send_byte(8'h02);
        checks++; if (buf_re !== 1'b1 || buf_raddr !== '0) begin
            errors++; $display("FAIL abort_read_start: got re=%b raddr=%0d, required 1 0", buf_re, buf_raddr);
        end
        wait_done(RD_CYCLES + 20, n);
        checks++; if (n != RD_CYCLES) begin errors++; $display("FAIL abort_read_cycles: got %0d, required %0d", n, RD_CYCLES); end
        checks++; if (exp_tx.size() != 0) begin errors++; $display("FAIL abort_leftover: got %0d pending, required 0", exp_tx.size()); end
        cyc();
    endtask

`ifdef UART_CMD_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        int done0;
        done0 = done_cnt;
        for (int i = 0; i < 10; i++) exp_wr.push_back(wr_t'{AW'(i), 8'(i + 40)});
        tx_ready = 1'b1;
        send_byte(8'h01);
        for (int i = 0; i < 10; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i + 40);
            cyc();
        end
        rx_valid = 1'b0;
        n = 0;
        while (err !== 1'b1 && n < TB_TIMEOUT + 100) begin
            cyc();
            n++;
        end
        checks++; if (n != TB_TIMEOUT) begin errors++; $display("FAIL timeout_cycles: got %0d, required %0d", n, TB_TIMEOUT); end
        checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_idle: got busy=%b tx_valid=%b, required 0 0", busy, tx_valid);
        end
        checks++; if (done_cnt != done0 || exp_wr.size() != 0) begin
            errors++; $display("FAIL timeout_side: got done=%0d pending=%0d, required 0 0", done_cnt - done0, exp_wr.size());
        end
        cyc();
    endtask
`else
    task automatic test_write_idle_wait();
        int n;
        int err0;
        err0 = err_cnt;
        for (int i = 0; i < DEPTH; i++) exp_wr.push_back(wr_t'{AW'(i), 8'(i) ^ 8'hC3});
        exp_tx.push_back(8'hA5);
        tx_ready = 1'b1;
        send_byte(8'h01);
        for (int i = 0; i < 10; i++) send_byte(8'(i) ^ 8'hC3);
        for (int i = 0; i < 200; i++) cyc();
        checks++; if (busy !== 1'b1 || tx_valid !== 1'b0 || err_cnt != err0) begin
            errors++; $display("FAIL idle_wait: got busy=%b tx_valid=%b err=%0d, required 1 0 0", busy, tx_valid, err_cnt - err0);
        end
        for (int i = 10; i < DEPTH; i++) send_byte(8'(i) ^ 8'hC3);
        wait_done(10, n);
        checks++; if (done !== 1'b1 || exp_wr.size() != 0 || exp_tx.size() != 0) begin
            errors++; $display("FAIL idle_wait_finish: got done=%b writes=%0d tx=%0d pending, required 1 0 0", done, exp_wr.size(), exp_tx.size());
        end
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_stall();
        test_bad_cmd();
        test_reset_abort();
`ifdef UART_CMD_TIMEOUT_EN
        test_timeout();
`else
        test_write_idle_wait();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
